// File: rtl/ram32x4_reader.sv
// Sequential read initiator: sweeps a synchronous RAM from address 0 to DEPTH-1, presenting each word on valid/ready.
// Optional read-and-clear mode is enabled by defining RAM32X4_READER_CLEAR_EN.
module ram32x4_reader #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT,
        CLEAR
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] oaddr_q;
    logic [DATA_W-1:0] odata_q;
    logic              ovalid_q;
    logic              busy_q;
    logic              done_q;

    always_comb begin
        cnt_d = cnt_q + ADDR_W'(1);
    end

`ifdef RAM32X4_READER_CLEAR_EN
    logic wren_q;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            oaddr_q  <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef RAM32X4_READER_CLEAR_EN
            wren_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ISSUE;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    odata_q  <= mem_q;
                    oaddr_q  <= cnt_q;
                    ovalid_q <= 1'b1;
                    state_q  <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        ovalid_q <= 1'b0;
`ifdef RAM32X4_READER_CLEAR_EN
                        wren_q  <= 1'b1;
                        state_q <= CLEAR;
`else
                        if (cnt_q == LAST) begin
                            state_q <= IDLE;
                            addr_q  <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_d;
                            addr_q  <= cnt_d;
                            state_q <= ISSUE;
                        end
`endif
                    end
                end
`ifdef RAM32X4_READER_CLEAR_EN
                // Write-back of zero happens at the edge ending this cycle; address still equals the counter.
                CLEAR: begin
                    wren_q <= 1'b0;
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        addr_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_d;
                        addr_q  <= cnt_d;
                        state_q <= ISSUE;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM32X4_READER_CLEAR_EN
    assign mem_wren = wren_q;
`else
    assign mem_wren = 1'b0;
`endif
    assign mem_data    = '0;
    assign mem_address = addr_q;
    assign out_addr    = oaddr_q;
    assign out_data    = odata_q;
    assign out_valid   = ovalid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ram32x4_reader.sv
// Bench for ram32x4_reader: table-driven sweeps against a RAM-snapshot reference, plus reset and start-hold sequences.
module tb_ram32x4_reader;

    localparam int AW    = 5;
    localparam int DW    = 4;
    localparam int DEPTH = 32;
`ifdef RAM32X4_READER_CLEAR_EN
    localparam int CPW = 4;
    localparam bit CLR = 1'b1;
`else
    localparam int CPW = 3;
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] mem_address;
    logic          mem_wren;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    ram32x4_reader #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clk),
        .resetn     (rst_n),
        .start      (start),
        .mem_address(mem_address),
        .mem_wren   (mem_wren),
        .mem_data   (mem_data),
        .mem_q      (mem_q),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    // Synchronous RAM with registered read; preload port is bench-only.
    logic [DW-1:0] ram    [DEPTH];
    logic [DW-1:0] pl_img [DEPTH];
    logic          pl_go = 1'b0;

    always @(posedge clk) begin
        if (pl_go) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pl_img[i];
        end else if (mem_wren) begin
            ram[mem_address] <= mem_data;
        end
        mem_q <= ram[mem_address];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string name;
        int    fill;
        int    stall_from;
        int    stall_to;
        int    restart_at;
        bit    rnd_ready;
        int    exp_xfers;
        int    exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic preload(input int fill);
        if (fill == 4) return;
        for (int i = 0; i < DEPTH; i++) begin
            case (fill)
                0:       pl_img[i] = DW'(i);
                1:       pl_img[i] = (i == 5) ? 4'hA : DW'(i);
                2:       pl_img[i] = DW'($urandom_range(0, 15));
                default: pl_img[i] = 4'hF;
            endcase
        end
        @(negedge clk) pl_go = 1'b1;
        @(negedge clk) pl_go = 1'b0;
    endtask

    task automatic sweep(input vec_t v);
        logic [DW-1:0] snap [DEPTH];
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        int k = 0, stalls = 0, ndone = 0, done_n = -1, first_v = -1, wr = 0, bad = 0;
        bit hold = 1'b0;
        preload(v.fill);
        for (int i = 0; i < DEPTH; i++) snap[i] = ram[i];
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            start = (n == v.restart_at);
            if (v.rnd_ready) out_ready = 1'($urandom_range(0, 1));
            else out_ready = !(n >= v.stall_from && n <= v.stall_to);
            if (n == 1) begin
                chk({v.name, ".busy1"}, busy, 1);
                chk({v.name, ".addr1"}, mem_address, 0);
                chk({v.name, ".valid1"}, out_valid, 0);
            end
            if (mem_wren) wr++;
            if (out_valid) begin
                if (first_v < 0) first_v = n;
                if (hold) begin
                    chk({v.name, ".hold_addr"}, out_addr, pa);
                    chk({v.name, ".hold_data"}, out_data, pd);
                end
                if (out_ready) begin
                    if (k < DEPTH) begin
                        chk({v.name, ".xfer_addr"}, out_addr, k);
                        chk({v.name, ".xfer_data"}, out_data, snap[k]);
                    end
                    k++;
                    hold = 1'b0;
                end else begin
                    stalls++;
                    hold = 1'b1;
                    pa = out_addr;
                    pd = out_data;
                    chk({v.name, ".stall_mem_addr"}, mem_address, out_addr);
                end
            end
            if (done) begin
                ndone++;
                if (done_n < 0) done_n = n;
                chk({v.name, ".busy_at_done"}, busy, 0);
            end
            if (done_n >= 0 && n >= done_n + 4) break;
        end
        out_ready = 1'b0;
        start = 1'b0;
        chk({v.name, ".xfers"}, k, v.exp_xfers);
        chk({v.name, ".done_count"}, ndone, v.exp_done);
        chk({v.name, ".latency"}, first_v - 1, 2);
        chk({v.name, ".sweep_cycles"}, done_n - 1, DEPTH * CPW + stalls);
        chk({v.name, ".wren_cycles"}, wr, CLR ? DEPTH : 0);
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== (CLR ? 4'h0 : snap[i])) bad++;
        chk({v.name, ".ram_after"}, bad, 0);
    endtask

    initial begin
        logic [DW-1:0] snap [DEPTH];
        int bad, found, dn;

        vecs.push_back('{"ramp",    0, 0, -1, -1, 1'b0, 32, 1});
        vecs.push_back('{"stall",   1, 10, 40, -1, 1'b0, 32, 1});
        vecs.push_back('{"restart", 0, 0, -1, 20, 1'b0, 32, 1});
        vecs.push_back('{"rand_a",  2, 0, -1, -1, 1'b1, 32, 1});
        vecs.push_back('{"rand_b",  2, 0, -1, 50, 1'b1, 32, 1});
        vecs.push_back('{"all_f",   3, 0, -1, -1, 1'b0, 32, 1});
        vecs.push_back('{"reread",  4, 0, -1, -1, 1'b0, 32, 1});

        // Reset state, held over clock edges.
        repeat (2) @(negedge clk);
        chk("rst.mem_address", mem_address, 0);
        chk("rst.mem_wren", mem_wren, 0);
        chk("rst.mem_data", mem_data, 0);
        chk("rst.out_addr", out_addr, 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) sweep(vecs[i]);

        // Asynchronous reset while word 12 is presented.
        preload(0);
        for (int i = 0; i < DEPTH; i++) snap[i] = ram[i];
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        found = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_addr == 12) begin
                found = 1;
                break;
            end
        end
        chk("midrst.reached_12", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.mem_address", mem_address, 0);
        chk("midrst.out_addr", out_addr, 0);
        chk("midrst.out_data", out_data, 0);
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.wren", mem_wren, 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== ((CLR && i < 12) ? 4'h0 : snap[i])) bad++;
        chk("midrst.ram", bad, 0);
        out_ready = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        sweep('{"after_rst", 0, 0, -1, -1, 1'b0, 32, 1});

        // start held high across done immediately launches the next sweep.
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        dn = -1;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (done) begin
                dn = n;
                break;
            end
        end
        chk("hold_start.done_cycle", dn - 1, DEPTH * CPW);
        @(negedge clk);
        chk("hold_start.busy_next", busy, 1);
        chk("hold_start.addr_next", mem_address, 0);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram32x4_reader.md
# ram32x4_reader

Sequential read initiator for the synchronous 32x4 RAM port: on a start pulse it sweeps every address from 0 to DEPTH-1. It drives address and write-enable, captures each read word after the RAM's one-cycle latency, and presents each (address, data) pair on a valid/ready output. It sits between the RAM and a consumer such as a display or serial dumper, replacing manual switch-driven reads.

## Interface
Parameters:
- ADDR_W, 5, RAM address width
- DATA_W, 4, RAM word width
- DEPTH, 32, number of words swept (2..2^ADDR_W); last address = DEPTH-1

Ports:
- clock  in  1  single clock, rising edge; same clock drives the RAM
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin sweep; sampled only in IDLE
- mem_address  out  ADDR_W  RAM address
- mem_wren  out  1  RAM write enable
- mem_data  out  DATA_W  RAM write data
- mem_q  in  DATA_W  RAM read data, valid the cycle after the address is registered by the RAM
- out_addr  out  ADDR_W  address of presented word
- out_data  out  DATA_W  presented word
- out_valid  out  1  presented pair valid
- out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- Reset values: mem_address=0, mem_wren=0, mem_data=0, out_addr=0, out_data=0, out_valid=0, busy=0, done=0, state=IDLE. Reset never alters RAM contents.
- States:
  - IDLE: when start=1, go to ISSUE; address counter=0.
  - ISSUE: mem_address=counter; go to WAIT.
  - WAIT: RAM output becomes valid; at the edge, latch out_data<=mem_q and out_addr<=counter, set out_valid=1, and go to PRESENT.
  - PRESENT: hold out_addr, out_data, out_valid stable until out_ready. On acceptance, clear out_valid. If counter==DEPTH-1, pulse done and go to IDLE. Otherwise increment counter and go to ISSUE (or to CLEAR, see Configuration).
- mem_address holds the counter in every non-IDLE state, and 0 in IDLE.
- The counter is ADDR_W bits and never wraps. A sweep ends exactly at DEPTH-1.
- start while busy: ignored, with no restart and no queueing. start held high across done: a new sweep begins on the cycle IDLE is re-entered.
- out_ready while out_valid=0: ignored.
- Reset mid-sweep: immediate return to reset values. The partially presented word is discarded.

## Timing
- Edge E0 samples start=1. Cycle after E0: ISSUE, with mem_address=0.
- E1: RAM registers the address.
- E2: out_valid rises, with out_data=RAM[0].
- Latency: out_valid asserts 2 cycles after the start-sampling edge.
- With out_ready tied high, throughput is one word per 3 cycles (ISSUE, WAIT, PRESENT). A full DEPTH=32 sweep takes 96 cycles from E0 to the done pulse.
- done is high for exactly the cycle after the edge that accepted word DEPTH-1; busy is 0 in that same cycle.
- Backpressure: each extra cycle of out_ready=0 in PRESENT adds one cycle. No data loss and no change in outputs.

## Configuration
- RAM32X4_READER_CLEAR_EN defined: read-and-clear mode. After each acceptance in PRESENT, the block spends one CLEAR cycle with mem_wren=1, mem_address=counter, mem_data=0. It then advances as above, or pulses done and returns to IDLE after the last word. Throughput becomes 4 cycles/word with ready high, so a DEPTH=32 sweep takes 128 cycles.
- Undefined: no CLEAR state; mem_wren and mem_data are constant 0.

## Test plan
- Preload RAM[a]=a[3:0]; pulse start; out_ready=1 -> 32 transfers with out_addr 0..31 and out_data 0..F,0..F. done pulses once, 96 cycles after the start edge.
- Preload RAM[5]=A; out_ready=0 from cycle 10 to cycle 40 -> out_valid stays high with out_addr and out_data frozen. No address advances. The sequence resumes in order with no skipped or duplicated words.
- Pulse start again at cycle 20 during a sweep -> no effect. Exactly 32 transfers, one done pulse.
- Assert resetn=0 mid-sweep at address 12 -> all outputs reset asynchronously, RAM unchanged. A new start yields a sweep from address 0 with the original data.
- With RAM32X4_READER_CLEAR_EN: preload all words to F; sweep -> 32 words read as F. A second sweep reads all 0, with 128 cycles per sweep. mem_wren is high for exactly one cycle per word.
- Without the macro: mem_wren is never 1 over the full sweep. RAM contents are identical before and after.
